// File: rtl/shared_reg_arb_pkg.sv
// shared_reg_arb_pkg: shared types, defaults and width helper for the shared register arbiter
package shared_reg_arb_pkg;
    typedef enum logic {IDLE, GRANT} state_t;
    localparam int N_REQ_DEF = 4;
    localparam int W_DEF = 8;
    localparam int HOLD_MAX_DEF = 4;
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit after last
module rr_pick import shared_reg_arb_pkg::*; #(
    parameter int N = N_REQ_DEF
) (
    input  logic [N-1:0]           req,
    input  logic [idx_w(N)-1:0]    last,
    output logic [N-1:0]           onehot,
    output logic [idx_w(N)-1:0]    idx,
    output logic                   valid
);
    localparam int IW = idx_w(N);
    logic [IW-1:0] pos;
    always_comb begin
        idx = '0;
        valid = 1'b0;
        pos = '0;
        for (int k = 1; k <= N; k++) begin
            pos = IW'((int'(last) + k) % N);
            if (!valid && req[pos]) begin
                valid = 1'b1;
                idx = pos;
            end
        end
        onehot = valid ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin write ownership and commit for one shared register
module shared_reg_arbiter import shared_reg_arb_pkg::*; #(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W = W_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ*W-1:0]        wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [idx_w(N_REQ)-1:0]   owner,
    output logic                      busy,
    output logic [W-1:0]              q,
    output logic                      q_valid
);
    localparam int IW = idx_w(N_REQ);
    localparam int HW = idx_w(HOLD_MAX);
    localparam logic [HW-1:0] HOLD_TOP = HW'(HOLD_MAX - 1);
    state_t state;
    logic [IW-1:0] last_owner;
    logic [HW-1:0] hold_cnt;
    logic [N_REQ-1:0] pick_oh;
    logic [IW-1:0] pick_idx;
    logic pick_valid;
    // while granted, last_owner equals owner, so masking gnt yields the next other requester
    rr_pick #(.N(N_REQ)) u_pick (
        .req    (state == GRANT ? req & ~gnt : req),
        .last   (last_owner),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt <= '0;
            owner <= '0;
            busy <= 1'b0;
            q <= '0;
            q_valid <= 1'b0;
            hold_cnt <= '0;
            last_owner <= IW'(N_REQ - 1);
        end else if (state == IDLE) begin
            if (pick_valid) begin
                state <= GRANT;
                gnt <= pick_oh;
                owner <= pick_idx;
                last_owner <= pick_idx;
                busy <= 1'b1;
                hold_cnt <= '0;
            end
        end else if (!req[owner]) begin
            state <= IDLE;
            gnt <= '0;
            busy <= 1'b0;
            hold_cnt <= '0;
        end else begin
            if (we[owner]) begin
                q <= wdata[owner*W +: W];
                q_valid <= 1'b1;
            end
            if (hold_cnt == HOLD_TOP && pick_valid) begin
                gnt <= pick_oh;
                owner <= pick_idx;
                last_owner <= pick_idx;
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_TOP) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed self-checking bench for shared_reg_arbiter
module tb_shared_reg_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] req, we, gnt;
    logic [31:0] wdata;
    logic [1:0] owner;
    logic busy, q_valid;
    logic [7:0] q;
    int tests = 0;
    int fails = 0;

    shared_reg_arbiter #(.N_REQ(4), .W(8), .HOLD_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .wdata(wdata),
        .gnt(gnt), .owner(owner), .busy(busy), .q(q), .q_valid(q_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req = 4'b1111;
        we = 4'b1111;
        wdata = 32'hFFFF_FFFF;
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_q", q, 0);
        chk("rst_qv", q_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        // single requester write
        rst_n = 1'b1;
        req = 4'b0100;
        we = 4'b0100;
        wdata = 32'h00A5_0000;
        tick();
        chk("single_gnt", gnt, 4'b0100);
        chk("single_owner", owner, 2);
        chk("single_busy", busy, 1);
        chk("single_q_before", q, 0);
        tick();
        chk("single_q", q, 8'hA5);
        chk("single_qv", q_valid, 1);
        // reset again so round robin starts from requester 0
        rst_n = 1'b0;
        req = 4'b0000;
        we = 4'b0000;
        tick();
        chk("rst2_q", q, 0);
        rst_n = 1'b1;
        req = 4'b1111;
        tick();
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("rr_%0d", i), gnt, 4'b0001 << ((i / 4) % 4));
            tick();
        end
        chk("rr_owner", owner, 1);
        // owner 1, non-owner writes blocked
        req = 4'b0010;
        we = 4'b1001;
        wdata = 32'h3300_7711;
        tick();
        chk("nonowner_q", q, 0);
        chk("nonowner_gnt", gnt, 4'b0010);
        we = 4'b0010;
        tick();
        chk("owner_q", q, 8'h77);
        // hand to requester 3 through idle
        req = 4'b1000;
        we = 4'b0000;
        tick();
        chk("rel1_gnt", gnt, 0);
        tick();
        chk("own3_gnt", gnt, 4'b1000);
        req = 4'b0000;
        we = 4'b1000;
        wdata = 32'hC300_0000;
        tick();
        chk("rel_gnt", gnt, 0);
        chk("rel_busy", busy, 0);
        chk("rel_q", q, 8'h77);
        chk("rel_owner", owner, 3);
        req = 4'b0001;
        we = 4'b0000;
        tick();
        chk("after_rel_gnt", gnt, 4'b0001);
        chk("after_rel_owner", owner, 0);
        // uncontested owner keeps grant past HOLD_MAX
        for (int i = 0; i < 6; i++) tick();
        chk("sat_gnt", gnt, 4'b0001);
        // saturated owner preempted directly, its last write commits
        req = 4'b0101;
        we = 4'b0001;
        wdata = 32'h0000_00E1;
        tick();
        chk("preempt_gnt", gnt, 4'b0100);
        chk("preempt_q", q, 8'hE1);
        chk("preempt_busy", busy, 1);
        // reset mid-write overrides commit
        we = 4'b0100;
        wdata = 32'h005A_0000;
        rst_n = 1'b0;
        tick();
        chk("midrst_q", q, 0);
        chk("midrst_gnt", gnt, 0);
        chk("midrst_qv", q_valid, 0);
        rst_n = 1'b1;
        req = 4'b0110;
        we = 4'b0000;
        tick();
        chk("postrst_gnt", gnt, 4'b0010);
        chk("postrst_owner", owner, 1);
        // release at handover threshold returns to idle
        tick();
        tick();
        tick();
        chk("thr_gnt", gnt, 4'b0010);
        req = 4'b0100;
        tick();
        chk("thr_rel_gnt", gnt, 0);
        tick();
        chk("thr_next_gnt", gnt, 4'b0100);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
